demux_16: RTL
=============

Name: demux_16

Overview:
- 1-to-NUM_LANES lane distributor; the write-side counterpart of the 16:1 lane mux.
- Accepts one DATA_W word per cycle on a valid/ready input stream.
- Steers each word to the lane named by in_sel, or to all lanes on broadcast.
- Each lane holds its word in a one-entry output buffer with its own valid/ready handshake.
- Sits between a single wide producer and 16 lane consumers; the packed lane vector feeds the existing lane-mux datapath.

Parameters:
- NUM_LANES, 16, number of output lanes (2..16).
- DATA_W, 128, word width.
- SEL_W, $clog2(NUM_LANES), derived localparam; not overridable.

Ports:
- clk  input  1  clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input word valid.
- in_ready  output  1  input word accepted when in_valid & in_ready.
- in_sel  input  SEL_W  destination lane index; ignored when in_bcast=1.
- in_bcast  input  1  write word to every lane.
- in_data  input  DATA_W  input word.
- out_valid  output  NUM_LANES  per-lane buffer occupied.
- out_ready  input  NUM_LANES  per-lane consumer ready.
- out_data  output  [0:NUM_LANES-1][DATA_W-1:0]  packed per-lane data.
- err_sticky  output  1  out-of-range select seen.
- err_clr  input  1  clears err_sticky.
- xfer_cnt  output  32  accepted-word counter.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - out_valid=0, out_data=0, err_sticky=0, xfer_cnt=0.
  - in_ready follows the combinational rule below (all lanes free, so in_ready=1).
- Per lane k:
  - pop_k = out_valid[k] & out_ready[k].
  - free_k = !out_valid[k] | out_ready[k], so pop and refill may happen in the same cycle.
- in_ready rules:
  - in_bcast=1: in_ready = AND of free_k over all lanes.
  - in_bcast=0 and in_sel < NUM_LANES: in_ready = free_{in_sel}.
  - in_bcast=0 and in_sel >= NUM_LANES (reachable only if NUM_LANES is not a power of 2): in_ready=1.
  - in_ready never depends on in_valid. It may depend combinationally on out_ready, in_sel and in_bcast.
- Accept (in_valid & in_ready):
  - Target lane(s) load in_data and set out_valid on the next edge. Latency is exactly 1 cycle.
  - There is no combinational path from in_data to out_data.
  - Broadcast loads all lanes in the same edge.
- Out-of-range accept:
  - Word is dropped; no lane changes.
  - err_sticky=1 next cycle.
  - xfer_cnt does not increment.
- Lane data hold: while out_valid[k]=1 and !out_ready[k], out_data[k] holds stable. Required; checked by assertion.
- Pop without refill: out_valid[k] clears next cycle. out_data[k] keeps its last value (don't-care to consumer).
- xfer_cnt: +1 per accepted in-range or broadcast word (broadcast counts 1). 32-bit, wraps 0xFFFFFFFF->0.
- err_clr:
  - Clears err_sticky next cycle.
  - If err_clr and an out-of-range accept occur in the same cycle, set wins (err_sticky=1).
- Throughput: a lane consumed every cycle sustains one word per cycle to that lane.
- Reset mid-operation: buffered words are discarded and all outputs return to reset values immediately; no handshake completes in that cycle.

Decomposition:
- Package demux_pkg holds:
  - default DATA_W and NUM_LANES constants;
  - typedef lane_idx_t (logic [SEL_W-1:0]);
  - typedef word_t (logic [DATA_W-1:0]).
- One sub-module, lane_buf: one-entry buffer with load, data_in, valid/ready out, and the free output.
- lane_buf is instantiated NUM_LANES times in a generate loop. The top holds select decode, in_ready, the error flag and the counter.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> out_valid=0, out_data=0, xfer_cnt=0, err_sticky=0, in_ready=1. Assert rst_n=0 while lane 3 is full -> out_valid[3]=0 immediately.
- Single steer: in_sel=5, data=128'hA5.., out_ready=0 -> next cycle only out_valid[5]=1 with that data, xfer_cnt=1. A second word to lane 5 -> in_ready=0 until out_ready[5]=1.
- Streaming: 16 words to lane 2 on consecutive cycles with out_ready[2]=1 -> in_ready stays 1, words appear in order at 1-cycle latency, xfer_cnt=16.
- Broadcast: lane 7 full with out_ready[7]=0, in_bcast=1 -> in_ready=0. Release out_ready[7] -> accepted, all 16 lanes valid with the same data, xfer_cnt +1.
- Out-of-range (NUM_LANES=12): in_sel=13 with err_clr=1 the same cycle -> accepted, no lane set, err_sticky=1, xfer_cnt unchanged. Next cycle err_clr=1 alone -> err_sticky=0.
- Counter wrap: force xfer_cnt=32'hFFFFFFFF, accept one word -> xfer_cnt=0.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the demux_16 lane distributor.
//   DEF_NUM_LANES / DEF_DATA_W : default lane count and word width
//   lane_idx_t                 : lane index at the default lane count
//   word_t                     : data word at the default width
package demux_pkg;

   localparam int DEF_NUM_LANES = 16;
   localparam int DEF_DATA_W    = 128;
   localparam int DEF_SEL_W     = $clog2(DEF_NUM_LANES);

   typedef logic [DEF_SEL_W-1:0]  lane_idx_t;
   typedef logic [DEF_DATA_W-1:0] word_t;

endpackage

// File: rtl/lane_buf.sv
// lane_buf: one-entry output buffer for a single demux lane.
//   clk, rst_n : clock, asynchronous active-low reset
//   load_i     : write data_i into the buffer on this edge
//   data_i     : word to store
//   ready_i    : consumer ready for this lane
//   valid_o    : buffer occupied
//   data_o     : buffered word (held stable while valid_o & !ready_i)
//   free_o     : buffer can take a word this cycle (empty or being popped)
module lane_buf
   import demux_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              free_o
);

   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q,  data_d;

   // A pop and a refill may share a cycle, so free looks through ready_i.
   assign free_o = !valid_q || ready_i;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end else if (ready_i) begin
         // Pop without refill: data is left in place, only valid drops.
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;

   a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
      (valid_q && !ready_i) |=> $stable(data_q));

endmodule

// File: rtl/demux_16.sv
// demux_16: 1-to-NUM_LANES lane distributor with per-lane one-entry buffers.
//   clk, rst_n  : clock, asynchronous active-low reset
//   in_valid    : input word valid
//   in_ready    : input accepted when in_valid & in_ready
//   in_sel      : destination lane (ignored on broadcast)
//   in_bcast    : write word to every lane
//   in_data     : input word
//   out_valid   : per-lane buffer occupied
//   out_ready   : per-lane consumer ready
//   out_data    : packed per-lane data, lane k at out_data[k]
//   err_sticky  : an out-of-range select was accepted and dropped
//   err_clr     : clears err_sticky (a same-cycle error wins)
//   xfer_cnt    : accepted in-range/broadcast words, wraps at 2^32
module demux_16
   import demux_pkg::*;
#(
   parameter  int NUM_LANES = DEF_NUM_LANES,
   parameter  int DATA_W    = DEF_DATA_W,
   localparam int SEL_W     = $clog2(NUM_LANES)
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [SEL_W-1:0]                    in_sel,
   input  logic                                in_bcast,
   input  logic [DATA_W-1:0]                   in_data,
   output logic [NUM_LANES-1:0]                out_valid,
   input  logic [NUM_LANES-1:0]                out_ready,
   output logic [0:NUM_LANES-1][DATA_W-1:0]    out_data,
   output logic                                err_sticky,
   input  logic                                err_clr,
   output logic [31:0]                         xfer_cnt
);

   logic [NUM_LANES-1:0] sel_hit;
   logic [NUM_LANES-1:0] lane_free;
   logic [NUM_LANES-1:0] lane_load;
   logic                 sel_in_range;
   logic                 accept;
   logic                 err_q, err_d;
   logic [31:0]          cnt_q, cnt_d;

   // One-hot decode; an index past the last lane leaves every bit clear.
   always_comb begin
      sel_hit = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         sel_hit[k] = (32'(in_sel) == k);
      end
   end

   assign sel_in_range = |sel_hit;

   // Out-of-range words are always taken so the producer never stalls on them.
   always_comb begin
      if (in_bcast) begin
         in_ready = &lane_free;
      end else if (sel_in_range) begin
         in_ready = |(sel_hit & lane_free);
      end else begin
         in_ready = 1'b1;
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      lane_load = '0;
      if (accept) begin
         lane_load = in_bcast ? '1 : sel_hit;
      end
   end

   always_comb begin
      err_d = err_q;
      cnt_d = cnt_q;
      if (accept && !in_bcast && !sel_in_range) begin
         err_d = 1'b1;
      end else if (err_clr) begin
         err_d = 1'b0;
      end
      if (accept && (in_bcast || sel_in_range)) begin
         cnt_d = cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= err_d;
         cnt_q <= cnt_d;
      end
   end

   assign err_sticky = err_q;
   assign xfer_cnt   = cnt_q;

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      lane_buf #(
         .DATA_W (DATA_W)
      ) u_lane (
         .clk     (clk),
         .rst_n   (rst_n),
         .load_i  (lane_load[k]),
         .data_i  (in_data),
         .ready_i (out_ready[k]),
         .valid_o (out_valid[k]),
         .data_o  (out_data[k]),
         .free_o  (lane_free[k])
      );
   end

endmodule
